// File: rtl/rx_pkg.sv
// rx_pkg: shared receiver field widths and the peak event record type
package rx_pkg;

    localparam int RX_PEAK_W = 41;
    localparam int RX_SEQ_W  = 4;
    localparam int RX_TIME_W = 16;

    // 61-bit event record; the timestamp field is "ts" because "time" is a keyword
    typedef struct packed {
        logic signed [RX_PEAK_W-1:0] sample;
        logic [RX_SEQ_W-1:0]         seq;
        logic [RX_TIME_W-1:0]        ts;
    } rx_event_t;

endpackage

// File: rtl/rx_event_ram.sv
// rx_event_ram: DEPTH x event register array, one sync write port, one async read port
module rx_event_ram
    import rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     crx_clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  rx_event_t                wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output rx_event_t                rd_data
);

    rx_event_t mem [DEPTH];

    // write port; contents are deliberately not reset
    always_ff @(posedge crx_clk)
        if (we) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_event_fifo.sv
// rx_event_fifo: first-word fall-through queue of correlation peak events
// Optional drop counter output o_drop_cnt is built when RX_EVT_DROP_CNT_EN is defined.
module rx_event_fifo
    import rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                        crx_clk,
    input  logic                        rrx_rst_n,
    input  logic                        erx_en,
    input  logic signed [RX_PEAK_W-1:0] i_sample,
    input  logic [RX_SEQ_W-1:0]         i_seq,
    input  logic [RX_TIME_W-1:0]        i_time,
    input  logic                        i_trigger,
    output logic signed [RX_PEAK_W-1:0] o_sample,
    output logic [RX_SEQ_W-1:0]         o_seq,
    output logic [RX_TIME_W-1:0]        o_time,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [LVL_W-1:0]            o_level,
    output logic                        o_overflow,
`ifdef RX_EVT_DROP_CNT_EN
    output logic [7:0]                  o_drop_cnt,
`endif
    input  logic                        i_clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             ovf, full, push, pop, drop;
    rx_event_t        wr_evt, rd_evt, hold, shown;

    assign full    = count == LVL_W'(DEPTH);
    assign o_valid = count != '0;
    assign pop     = o_valid & i_ready;
    // a pop in the same cycle frees the slot, so a full queue still accepts the push
    assign push    = i_trigger & erx_en & (~full | pop);
    assign drop    = i_trigger & erx_en & full & ~pop;
    assign wr_evt  = {i_sample, i_seq, i_time};

    rx_event_ram #(.DEPTH(DEPTH)) u_ram (
        .crx_clk (crx_clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_evt),
        .rd_addr (rd_ptr),
        .rd_data (rd_evt)
    );

    // pointers, occupancy and sticky overflow; a drop outranks a same-cycle clear
    always_ff @(posedge crx_clk or negedge rrx_rst_n)
        if (!rrx_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (!erx_en) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + LVL_W'(push) - LVL_W'(pop);
            ovf    <= drop | (ovf & ~i_clr_ovf);
        end

    // remember the last head shown so outputs hold while empty and read 0 out of reset
    always_ff @(posedge crx_clk or negedge rrx_rst_n)
        if (!rrx_rst_n) hold <= '0;
        else            hold <= shown;

    assign shown      = o_valid ? rd_evt : hold;
    assign o_sample   = shown.sample;
    assign o_seq      = shown.seq;
    assign o_time     = shown.ts;
    assign o_level    = count;
    assign o_overflow = ovf;

`ifdef RX_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // saturating drop counter; a clear racing a drop leaves exactly that drop counted
    always_ff @(posedge crx_clk or negedge rrx_rst_n)
        if (!rrx_rst_n)                  drop_cnt <= '0;
        else if (!erx_en)                drop_cnt <= '0;
        else if (i_clr_ovf)              drop_cnt <= {7'd0, drop};
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 8'd1;

    assign o_drop_cnt = drop_cnt;
`endif

endmodule
